// File: rtl/ps2_pkg.sv
// ps2_pkg: shared PS/2 decoder states, prefix constants and the queued event record
package ps2_pkg;
  typedef enum logic [2:0] {ST_IDLE, ST_EXT, ST_BRK, ST_EXT_BRK, ST_SKIP} ps2_state_t;
  localparam logic [7:0] PS2_PFX_EXT = 8'hE0;
  localparam logic [7:0] PS2_PFX_BRK = 8'hF0;
  localparam logic [7:0] PS2_PFX_PAUSE = 8'hE1;
  localparam int PS2_PAUSE_LEN = 7;
  typedef struct packed {
    logic [7:0] code;
    logic ext;
    logic brk;
  } ps2_event_t;
endpackage

// File: rtl/ps2_event_fifo.sv
// ps2_event_fifo: first-word-fall-through event queue; a pop on a full queue frees room for a same-cycle push
module ps2_event_fifo
  import ps2_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  ps2_event_t din,
  input  logic       pop,
  output ps2_event_t dout,
  output logic       full,
  output logic       empty
);
  localparam int AW = $clog2(DEPTH);
  ps2_event_t mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] cnt;
  logic wr, rd;
  assign empty = cnt == '0;
  assign full = cnt == (AW+1)'(DEPTH);
  assign rd = pop & ~empty;
  assign wr = push & (~full | rd);
  // Head reads as zero while empty so the outputs are defined right after reset
  assign dout = empty ? '0 : mem[rd_ptr];
  always_ff @(posedge clk)
    if (wr) mem[wr_ptr] <= din;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(wr);
      rd_ptr <= rd_ptr + AW'(rd);
      cnt <= cnt + (AW+1)'(wr) - (AW+1)'(rd);
    end
  end
endmodule

// File: rtl/ps2_key_event_ctrl.sv
// ps2_key_event_ctrl: PS/2 scan-code prefix decoder feeding an event queue;
// define PS2_TYPEMATIC_FILTER_EN to suppress typematic repeats of the held key
module ps2_key_event_ctrl
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_valid,
  input  logic [7:0] rx_byte,
  input  logic       rx_err,
  output logic       ev_valid,
  input  logic       ev_ready,
  output logic [7:0] ev_code,
  output logic       ev_ext,
  output logic       ev_break,
  output logic       ev_overflow,
  input  logic       ovf_clr,
  output logic       busy
);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  ps2_state_t state, state_d;
  logic [TW-1:0] to_cnt;
  logic [2:0] skip_cnt;
  logic vld, is_pfx, timeout, cand, dec_push, push_q, fifo_full, fifo_empty, drop;
  ps2_event_t dec_ev, ev_q, head;
  assign vld = rx_valid & ~rx_err;
  assign is_pfx = rx_byte == PS2_PFX_EXT || rx_byte == PS2_PFX_BRK;
  assign timeout = state != ST_IDLE && !rx_valid && to_cnt == TW'(TIMEOUT_CYC - 1);
  assign busy = state != ST_IDLE;
  always_ff @(posedge clk)
    if (!rst_n) state <= ST_IDLE;
    else state <= state_d;
  always_comb begin
    state_d = state;
    if (rx_err || timeout) state_d = ST_IDLE;
    else if (vld)
      case (state)
        ST_IDLE: state_d = rx_byte == PS2_PFX_EXT ? ST_EXT : rx_byte == PS2_PFX_BRK ? ST_BRK :
                           rx_byte == PS2_PFX_PAUSE ? ST_SKIP : ST_IDLE;
        ST_EXT:  state_d = rx_byte == PS2_PFX_BRK ? ST_EXT_BRK : rx_byte == PS2_PFX_EXT ? ST_EXT : ST_IDLE;
        ST_SKIP: state_d = skip_cnt == 3'(PS2_PAUSE_LEN - 1) ? ST_IDLE : ST_SKIP;
        default: state_d = ST_IDLE;
      endcase
  end
  always_comb begin
    dec_ev.code = rx_byte;
    dec_ev.ext = state == ST_EXT || state == ST_EXT_BRK;
    dec_ev.brk = state == ST_BRK || state == ST_EXT_BRK;
    cand = vld && !is_pfx && state != ST_SKIP && !(state == ST_IDLE && rx_byte == PS2_PFX_PAUSE);
  end
`ifdef PS2_TYPEMATIC_FILTER_EN
  logic held_v, held_ext, held_hit;
  logic [7:0] held_code;
  assign held_hit = held_v && held_ext == dec_ev.ext && held_code == rx_byte;
  assign dec_push = cand && !(held_hit && !dec_ev.brk);
  always_ff @(posedge clk)
    if (!rst_n) {held_v, held_ext, held_code} <= '0;
    else if (cand && !dec_ev.brk) {held_v, held_ext, held_code} <= {1'b1, dec_ev.ext, rx_byte};
    else if (cand && held_hit) held_v <= 1'b0;
`else
  assign dec_push = cand;
`endif
  assign drop = push_q & fifo_full & ~(ev_ready & ~fifo_empty);
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      to_cnt <= '0;
      skip_cnt <= '0;
      push_q <= 1'b0;
      ev_q <= '0;
      ev_overflow <= 1'b0;
    end else begin
      to_cnt <= (rx_valid || state_d == ST_IDLE) ? '0 : to_cnt + 1'b1;
      skip_cnt <= state_d != ST_SKIP ? '0 : (state == ST_SKIP && vld) ? skip_cnt + 3'd1 : skip_cnt;
      push_q <= dec_push;
      ev_q <= dec_ev;
      ev_overflow <= drop | (ev_overflow & ~ovf_clr);
    end
  end
  ps2_event_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk), .rst_n(rst_n), .push(push_q), .din(ev_q), .pop(ev_ready),
    .dout(head), .full(fifo_full), .empty(fifo_empty)
  );
  assign ev_valid = ~fifo_empty;
  assign ev_code = head.code;
  assign ev_ext = head.ext;
  assign ev_break = head.brk;
endmodule

// File: tb/tb_ps2_key_event_ctrl.sv
// tb_ps2_key_event_ctrl: directed vector table plus hand-timed sequences for latency, overflow, timeout and reset
module tb_ps2_key_event_ctrl;
  localparam int T = 20;
  logic clk = 0, rst_n = 0, rx_valid = 0, rx_err = 0, ev_ready = 1, ovf_clr = 0;
  logic [7:0] rx_byte = '0;
  logic ev_valid, ev_ext, ev_break, ev_overflow, busy;
  logic [7:0] ev_code;
  int n_chk = 0, n_pass = 0;
  logic [9:0] got [$];

  typedef struct packed {
    logic [3:0] nb;
    logic [0:9][7:0] b;
    logic [2:0] ne;
    logic [0:3][9:0] e;
  } vec_t;
  vec_t tv [8];

  ps2_key_event_ctrl #(.FIFO_DEPTH(4), .TIMEOUT_CYC(T)) dut (
    .clk(clk), .rst_n(rst_n), .rx_valid(rx_valid), .rx_byte(rx_byte), .rx_err(rx_err),
    .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_code(ev_code), .ev_ext(ev_ext),
    .ev_break(ev_break), .ev_overflow(ev_overflow), .ovf_clr(ovf_clr), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) if (rst_n && ev_valid && ev_ready) got.push_back({ev_code, ev_ext, ev_break});

  function automatic logic [9:0] ev(input logic [7:0] c, input logic x, input logic k);
    return {c, x, k};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    else n_pass++;
  endtask

  task automatic send(input logic [7:0] b, input logic err);
    @(negedge clk);
    rx_valid = 1; rx_byte = b; rx_err = err;
    @(negedge clk);
    rx_valid = 0; rx_err = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 0; rx_valid = 0; rx_err = 0; ovf_clr = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
    got.delete();
  endtask

  task automatic check_got(input string nm, input int ne, input logic [0:3][9:0] e);
    chk({nm, "_count"}, got.size(), ne);
    for (int i = 0; i < ne; i++)
      chk($sformatf("%s_ev%0d", nm, i), i < got.size() ? 32'(got[i]) : 32'hFFFF_FFFF, 32'(e[i]));
  endtask

  initial begin
    tv[0] = '{4'd3, {8'h1C, 8'hF0, 8'h1C, 56'h0}, 3'd2, {ev(8'h1C, 0, 0), ev(8'h1C, 0, 1), 20'h0}};
    tv[1] = '{4'd5, {8'hE0, 8'h75, 8'hE0, 8'hF0, 8'h75, 40'h0}, 3'd2, {ev(8'h75, 1, 0), ev(8'h75, 1, 1), 20'h0}};
    tv[2] = '{4'd9, {8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77, 8'h1C, 8'h0}, 3'd1,
              {ev(8'h1C, 0, 0), 30'h0}};
`ifdef PS2_TYPEMATIC_FILTER_EN
    tv[3] = '{4'd5, {8'h1D, 8'h1D, 8'h1D, 8'hF0, 8'h1D, 40'h0}, 3'd2, {ev(8'h1D, 0, 0), ev(8'h1D, 0, 1), 20'h0}};
`else
    tv[3] = '{4'd5, {8'h1D, 8'h1D, 8'h1D, 8'hF0, 8'h1D, 40'h0}, 3'd4,
              {ev(8'h1D, 0, 0), ev(8'h1D, 0, 0), ev(8'h1D, 0, 0), ev(8'h1D, 0, 1)}};
`endif
    tv[4] = '{4'd3, {8'hF0, 8'hE0, 8'h2A, 56'h0}, 3'd1, {ev(8'h2A, 0, 0), 30'h0}};
    tv[5] = '{4'd3, {8'hE0, 8'hE0, 8'h6B, 56'h0}, 3'd1, {ev(8'h6B, 1, 0), 30'h0}};
    tv[6] = '{4'd4, {8'hE0, 8'hF0, 8'hF0, 8'h11, 48'h0}, 3'd1, {ev(8'h11, 0, 0), 30'h0}};
    tv[7] = '{4'd1, {8'h5A, 72'h0}, 3'd1, {ev(8'h5A, 0, 0), 30'h0}};

    do_reset();
    chk("rst_valid", ev_valid, 0);
    chk("rst_code", ev_code, 0);
    chk("rst_ext", ev_ext, 0);
    chk("rst_break", ev_break, 0);
    chk("rst_ovf", ev_overflow, 0);
    chk("rst_busy", busy, 0);

    for (int v = 0; v < 8; v++) begin
      do_reset();
      ev_ready = 1;
      for (int i = 0; i < int'(tv[v].nb); i++) send(tv[v].b[i], 0);
      repeat (6) @(negedge clk);
      check_got($sformatf("vec%0d", v), int'(tv[v].ne), tv[v].e);
    end

    // latency and head stability with the consumer stalled
    do_reset();
    ev_ready = 0;
    send(8'h1C, 0);
    chk("lat_cyc1_valid", ev_valid, 0);
    @(negedge clk);
    chk("lat_cyc2_valid", ev_valid, 1);
    chk("lat_code", ev_code, 8'h1C);
    send(8'h2D, 0);
    repeat (4) @(negedge clk);
    chk("hold_code", ev_code, 8'h1C);
    chk("hold_valid", ev_valid, 1);

    do_reset();
    ev_ready = 1;
    send(8'hE0, 0);
    chk("busy_after_pfx", busy, 1);
    send(8'h75, 0);
    chk("busy_after_code", busy, 0);

    // overflow, clear, full-plus-pop, clear colliding with a new drop
    do_reset();
    ev_ready = 0;
    send(8'h11, 0); send(8'h22, 0); send(8'h33, 0); send(8'h44, 0); send(8'h55, 0);
    repeat (3) @(negedge clk);
    chk("ovf_set", ev_overflow, 1);
    chk("ovf_head", ev_code, 8'h11);
    ovf_clr = 1;
    @(negedge clk);
    ovf_clr = 0;
    chk("ovf_clr", ev_overflow, 0);
    send(8'h66, 0);
    ev_ready = 1;
    @(negedge clk);
    ev_ready = 0;
    @(negedge clk);
    chk("full_pop_ovf", ev_overflow, 0);
    chk("full_pop_got", got.size() > 0 ? 32'(got[0]) : 32'hFFFF_FFFF, 32'(ev(8'h11, 0, 0)));
    send(8'h77, 0);
    ovf_clr = 1;
    @(negedge clk);
    ovf_clr = 0;
    chk("clr_vs_drop", ev_overflow, 1);
    got.delete();
    ev_ready = 1;
    repeat (6) @(negedge clk);
    check_got("drain", 4, {ev(8'h22, 0, 0), ev(8'h33, 0, 0), ev(8'h44, 0, 0), ev(8'h66, 0, 0)});

    // timeout boundary: still pending one cycle before, abandoned at the limit
    do_reset();
    send(8'hE0, 0);
    repeat (T - 1) @(negedge clk);
    chk("to_before", busy, 1);
    @(negedge clk);
    chk("to_at", busy, 0);
    send(8'h1C, 0);
    repeat (4) @(negedge clk);
    check_got("to_after", 1, {ev(8'h1C, 0, 0), 30'h0});
    do_reset();
    send(8'hE0, 0);
    repeat (T - 3) @(negedge clk);
    send(8'h1C, 0);
    repeat (4) @(negedge clk);
    check_got("to_within", 1, {ev(8'h1C, 1, 0), 30'h0});

    do_reset();
    send(8'hE0, 1);
    chk("err_busy", busy, 0);
    send(8'hE0, 0);
    send(8'h75, 1);
    chk("err_mid_busy", busy, 0);
    send(8'h1C, 0);
    repeat (4) @(negedge clk);
    check_got("err", 1, {ev(8'h1C, 0, 0), 30'h0});

    // reset with queued events and a pending break prefix
    do_reset();
    ev_ready = 0;
    send(8'h11, 0); send(8'h22, 0); send(8'hF0, 0);
    repeat (3) @(negedge clk);
    chk("pre_rst_valid", ev_valid, 1);
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    chk("mid_rst_valid", ev_valid, 0);
    chk("mid_rst_busy", busy, 0);
    got.delete();
    ev_ready = 1;
    send(8'h1C, 0);
    repeat (4) @(negedge clk);
    check_got("post_rst", 1, {ev(8'h1C, 0, 0), 30'h0});

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/ps2_key_event_ctrl.md
PS2_KEY_EVENT_CTRL -- requirements
Module: ps2_key_event_ctrl

Interface
REQ-001 Parameter FIFO_DEPTH, default 4: event queue depth; power of two, 2..16.
REQ-002 Parameter TIMEOUT_CYC, default 50000: idle clk cycles after which a partial prefix sequence is abandoned (1 ms at 50 MHz).
REQ-003 Port clk  in  1: 50 MHz system clock; all logic on posedge clk. One clock; reset is synchronous and active-low (rst_n).
REQ-004 Port rst_n  in  1: synchronous active-low reset.
REQ-005 Port rx_valid  in  1: one-cycle strobe, rx_byte holds a complete received PS/2 byte.
REQ-006 Port rx_byte  in  8: received scan-code byte.
REQ-007 Port rx_err  in  1: one-cycle strobe, frame/parity error on the current byte.
REQ-008 Port ev_valid  out  1: queue non-empty; head event presented.
REQ-009 Port ev_ready  in  1: consumer accepts head when ev_valid & ev_ready.
REQ-010 Port ev_code  out  8: head event scan code, prefixes stripped.
REQ-011 Port ev_ext  out  1: head event carried E0 prefix.
REQ-012 Port ev_break  out  1: 1 = key release, 0 = key press.
REQ-013 Port ev_overflow  out  1: sticky, an event was dropped because the queue was full.
REQ-014 Port ovf_clr  in  1: clears ev_overflow.
REQ-015 Port busy  out  1: decoder not in IDLE (prefix pending).

Function
REQ-016 Decoder FSM states IDLE, EXT, BRK, EXT_BRK, SKIP.
REQ-017 IDLE: E0->EXT; F0->BRK; E1->SKIP; other byte->push {code,ext=0,brk=0}, stay IDLE.
REQ-018 EXT: F0->EXT_BRK; E0->stay EXT; other->push {code,1,0}, IDLE.
REQ-019 BRK: other than E0/F0->push {code,0,1}, IDLE; E0/F0->IDLE, no push.
REQ-020 EXT_BRK: other than E0/F0->push {code,1,1}, IDLE; E0/F0->IDLE, no push.
REQ-021 SKIP (Pause sequence): discard bytes; return to IDLE after 7 bytes counted, no push.
REQ-022 rx_err in any state: byte discarded, FSM->IDLE, no push; rx_err overrides rx_valid in the same cycle.
REQ-023 Timeout counter cleared on every rx_valid; in non-IDLE states, TIMEOUT_CYC consecutive cycles without rx_valid force IDLE, no push.
REQ-024 Push occurs in the cycle after the completing rx_valid; ev_valid asserted the cycle after that (2-cycle latency rx_valid->ev_valid on an empty queue).
REQ-025 Queue is first-word-fall-through; ev_code/ev_ext/ev_break stable while ev_valid & !ev_ready.
REQ-026 Push while full with no pop: event dropped, ev_overflow set next cycle.
REQ-027 Push while full with a pop in the same cycle: push accepted, no overflow.
REQ-028 Pop and push on empty queue in the same cycle: push accepted, pop ignored (ev_valid was low).
REQ-029 ovf_clr and a new overflow in the same cycle: ev_overflow remains 1.
REQ-030 Pointers wrap modulo FIFO_DEPTH; occupancy counter width clog2(FIFO_DEPTH)+1.

Reset
REQ-031 rst_n low at posedge clk: FSM->IDLE, SKIP counter 0, timeout counter 0, queue empty, ev_valid 0, ev_code 8'h00, ev_ext 0, ev_break 0, ev_overflow 0, busy 0, held-key valid 0.
REQ-032 Reset mid-sequence discards any partial prefix and all queued events; no event emitted after release.

Configuration
REQ-033 Macro PS2_TYPEMATIC_FILTER_EN defined: held register {valid,ext,code}; make equal to held key suppressed (no push); different make pushed and replaces held; break matching held pushed and clears valid.
REQ-034 Macro undefined: every decoded make is pushed, including typematic repeats; no held register.

Structure
REQ-035 Package ps2_pkg holds state enum, constants PS2_PFX_EXT 8'hE0, PS2_PFX_BRK 8'hF0, PS2_PFX_PAUSE 8'hE1, PS2_PAUSE_LEN 7, and the packed event struct {code,ext,brk}.
REQ-036 Sub-module ps2_event_fifo (parameterised depth, FWFT, full/empty, simultaneous push/pop) instantiated once.

Verification
REQ-037 Bytes 1C, F0, 1C -> events {1C,0,0} then {1C,0,1}; ev_valid 2 cycles after first rx_valid.
REQ-038 Bytes E0, 75, E0, F0, 75 -> {75,1,0} then {75,1,1}; busy high between prefix and code.
REQ-039 5 makes with ev_ready=0, depth 4 -> 4 queued, 5th dropped, ev_overflow=1; ovf_clr -> 0; full-plus-pop push accepted.
REQ-040 E0 then TIMEOUT_CYC idle cycles then 1C -> single event {1C,0,0}; E0 with rx_err -> no event; E1 14 77 E1 F0 14 F0 77 -> no events, then 1C -> {1C,0,0}.
REQ-041 With PS2_TYPEMATIC_FILTER_EN: 1D,1D,1D,F0,1D -> {1D,0,0},{1D,0,1} only; without macro -> three makes then break.
REQ-042 rst_n low after F0 received, then 1C -> {1C,0,0} (break prefix lost), queue previously holding 2 events empty.
